lamp_channel_engine: RTL

//  Parametrised N-channel lamp core, successor to the fixed 4-channel RGBW datapath.

---
 rtl/lamp_pkg.sv | 32 +++
 rtl/lamp_fade_ch.sv | 130 +++++++++++++
 rtl/lamp_channel_engine.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/lamp_pkg.sv
// Shared definitions for the lamp channel engine.
// Holds the command op codes, the command FSM state encoding, the fade
// rate width and the payload-length helper used by the command decoder.
package lamp_pkg;

    // Command byte op field [7:6]
    typedef enum logic [1:0] {
        OP_WR_TGT  = 2'b00,
        OP_WR_RATE = 2'b01,
        OP_COMMIT  = 2'b10,
        OP_ALL_OFF = 2'b11
    } op_t;

    // Command decoder states
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    // Fade rate is always a single payload byte
    localparam int RATE_W = 8;

    // Number of payload bytes following a command byte.
    function automatic logic [1:0] payload_len(input op_t op, input int pwm_w);
        case (op)
            OP_WR_TGT:  payload_len = 2'(pwm_w / 8);
            OP_WR_RATE: payload_len = 2'd1;
            default:    payload_len = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/lamp_fade_ch.sv
// One lamp channel: shadow/active targets, fade rate, current duty with
// clamped fade stepping, a duty latch reloaded only at PWM wrap, and the
// registered PWM compare.
// Ports:
//   clk12, reset       clock, asynchronous active-low reset
//   wr_tgt / wr_rate   write strobes for shadow target / fade rate (data on wr_data)
//   commit, all_off    copy shadow->active / force targets and current to 0
//   tick               fade tick strobe
//   cnt, cnt_wrap      shared PWM counter and its wrap flag (cnt == max)
//   pwm                registered PWM output
//   busy               current != active (unregistered, reduced in the top)
module lamp_fade_ch
    import lamp_pkg::*;
#(
    parameter int PWM_W = 16
) (
    input  logic             clk12,
    input  logic             reset,
    input  logic             wr_tgt,
    input  logic             wr_rate,
    input  logic [PWM_W-1:0] wr_data,
    input  logic             commit,
    input  logic             all_off,
    input  logic             tick,
    input  logic [PWM_W-1:0] cnt,
    input  logic             cnt_wrap,
    output logic             pwm,
    output logic             busy
);

    logic [PWM_W-1:0]  shadow_r;
    logic [PWM_W-1:0]  active_r;
    logic [PWM_W-1:0]  current_r;
    logic [RATE_W-1:0] rate_r;
    logic [PWM_W-1:0]  duty_r;
    logic              pwm_r;

    logic [PWM_W-1:0]  rate_ext_s;
    logic [PWM_W-1:0]  diff_s;
    logic [PWM_W-1:0]  step_s;
    logic [PWM_W-1:0]  current_next_s;
    logic              pwm_next_s;

    // One fade step toward active; the remaining distance is compared before
    // adding/subtracting, so the step can neither overshoot nor wrap.
    always_comb begin
        rate_ext_s = PWM_W'(rate_r);
        diff_s     = '0;
        step_s     = current_r;
        if (current_r < active_r) begin
            diff_s = active_r - current_r;
            if (diff_s <= rate_ext_s) begin
                step_s = active_r;
            end else begin
                step_s = current_r + rate_ext_s;
            end
        end else if (current_r > active_r) begin
            diff_s = current_r - active_r;
            if (diff_s <= rate_ext_s) begin
                step_s = active_r;
            end else begin
                step_s = current_r - rate_ext_s;
            end
        end else begin
            step_s = active_r;
        end
    end

    // Next current duty: ALL_OFF wins, rate 0 tracks active every cycle,
    // otherwise step only on tick (uses the pre-commit active value).
    always_comb begin
        current_next_s = current_r;
        if (all_off) begin
            current_next_s = '0;
        end else if (rate_r == '0) begin
            current_next_s = active_r;
        end else if (tick) begin
            current_next_s = step_s;
        end else begin
            current_next_s = current_r;
        end
    end

    // All-ones duty must give a constant high even at cnt == max.
    always_comb begin
        pwm_next_s = (duty_r == {PWM_W{1'b1}}) || (cnt < duty_r);
    end

    // Target, rate and current duty registers.
    always_ff @(posedge clk12 or negedge reset) begin
        if (!reset) begin
            shadow_r  <= '0;
            active_r  <= '0;
            current_r <= '0;
            rate_r    <= '0;
        end else begin
            if (all_off) begin
                shadow_r <= '0;
            end else if (wr_tgt) begin
                shadow_r <= wr_data;
            end
            if (all_off) begin
                active_r <= '0;
            end else if (commit) begin
                active_r <= shadow_r;
            end
            if (wr_rate) begin
                rate_r <= wr_data[RATE_W-1:0];
            end
            current_r <= current_next_s;
        end
    end

    // Duty latch reloads only at wrap so a period never changes mid-way.
    always_ff @(posedge clk12 or negedge reset) begin
        if (!reset) begin
            duty_r <= '0;
            pwm_r  <= 1'b0;
        end else begin
            if (cnt_wrap) begin
                duty_r <= current_r;
            end
            pwm_r <= pwm_next_s;
        end
    end

    assign pwm  = pwm_r;
    assign busy = (current_r != active_r);

endmodule

// File: rtl/lamp_channel_engine.sv
// N-channel lamp core. Decodes the spiSlave byte stream into per-channel
// double-buffered targets and fade rates, runs the fade prescaler and the
// shared PWM counter, and instantiates one lamp_fade_ch per channel.
// Ports:
//   clk12        system clock
//   reset        asynchronous active-low reset
//   rx_data      received byte, valid with rx_rdy
//   rx_rdy       one-cycle byte strobe
//   cs           SPI chip select (active low, high = frame boundary)
//   pwm_o        PWM outputs, bit i = channel i
//   busy_o       registered: some channel still fading
//   applied_o    one-cycle pulse after COMMIT
//   frame_err_o  one-cycle pulse on aborted payload or out-of-range channel
module lamp_channel_engine
    import lamp_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int PWM_W    = 16,
    parameter int TICK_DIV = 1024
) (
    input  logic           clk12,
    input  logic           reset,
    input  logic [7:0]     rx_data,
    input  logic           rx_rdy,
    input  logic           cs,
    output logic [NCH-1:0] pwm_o,
    output logic           busy_o,
    output logic           applied_o,
    output logic           frame_err_o
);

    localparam int                   PRESC_W   = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0]   PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    state_t            state_r;
    state_t            state_next_s;
    op_t               op_r;
    op_t               rx_op_s;
    logic [5:0]        ch_r;
    logic [1:0]        left_r;
    logic [PWM_W-1:0]  shift_r;
    logic [PWM_W-1:0]  shift_next_s;
    logic [PWM_W-1:0]  data_r;
    logic [5:0]        wr_ch_r;
    logic              wr_tgt_r;
    logic              wr_rate_r;
    logic              applied_r;
    logic              ferr_r;
    logic              busy_r;
    logic [PRESC_W-1:0] presc_r;
    logic [PWM_W-1:0]  cnt_r;

    logic              cmd_load_s;
    logic              commit_s;
    logic              all_off_s;
    logic              shift_en_s;
    logic              last_s;
    logic              abort_s;
    logic              ch_valid_s;
    logic              tick_s;
    logic              wrap_s;
    logic [NCH-1:0]    busy_vec_s;

    assign rx_op_s      = op_t'(rx_data[7:6]);
    assign shift_next_s = PWM_W'({shift_r, rx_data});
    assign ch_valid_s   = ({1'b0, ch_r} < 7'(NCH));
    assign tick_s       = (presc_r == PRESC_MAX);
    assign wrap_s       = (cnt_r == {PWM_W{1'b1}});

    // Command decoder next state and strobes. COMMIT/ALL_OFF act on the
    // command byte itself; cs high during a payload aborts it.
    always_comb begin
        state_next_s = state_r;
        cmd_load_s   = 1'b0;
        commit_s     = 1'b0;
        all_off_s    = 1'b0;
        shift_en_s   = 1'b0;
        last_s       = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_rdy && !cs) begin
                    case (rx_op_s)
                        OP_WR_TGT, OP_WR_RATE: begin
                            cmd_load_s   = 1'b1;
                            state_next_s = ST_PAYLOAD;
                        end
                        OP_COMMIT:  commit_s  = 1'b1;
                        OP_ALL_OFF: all_off_s = 1'b1;
                        default:    state_next_s = ST_IDLE;
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (cs) begin
                    abort_s      = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (rx_rdy) begin
                    shift_en_s = 1'b1;
                    if (left_r == 2'd1) begin
                        last_s       = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_PAYLOAD;
                    end
                end else begin
                    state_next_s = ST_PAYLOAD;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Command decoder state register.
    always_ff @(posedge clk12 or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Command capture, payload shift and the delayed channel write strobes.
    always_ff @(posedge clk12 or negedge reset) begin
        if (!reset) begin
            op_r      <= OP_WR_TGT;
            ch_r      <= 6'd0;
            left_r    <= 2'd0;
            shift_r   <= '0;
            data_r    <= '0;
            wr_ch_r   <= 6'd0;
            wr_tgt_r  <= 1'b0;
            wr_rate_r <= 1'b0;
        end else begin
            if (cmd_load_s) begin
                op_r    <= rx_op_s;
                ch_r    <= rx_data[5:0];
                left_r  <= payload_len(rx_op_s, PWM_W);
                shift_r <= '0;
            end else if (shift_en_s) begin
                shift_r <= shift_next_s;
                left_r  <= left_r - 2'd1;
            end
            if (last_s) begin
                data_r  <= shift_next_s;
                wr_ch_r <= ch_r;
            end
            wr_tgt_r  <= last_s && ch_valid_s && (op_r == OP_WR_TGT);
            wr_rate_r <= last_s && ch_valid_s && (op_r == OP_WR_RATE);
        end
    end

    // Free-running fade prescaler and PWM counter.
    always_ff @(posedge clk12 or negedge reset) begin
        if (!reset) begin
            presc_r <= '0;
            cnt_r   <= '0;
        end else begin
            presc_r <= tick_s ? '0 : presc_r + PRESC_W'(1);
            cnt_r   <= cnt_r + PWM_W'(1);
        end
    end

    // Registered status pulses and busy flag.
    always_ff @(posedge clk12 or negedge reset) begin
        if (!reset) begin
            applied_r <= 1'b0;
            ferr_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            applied_r <= commit_s;
            ferr_r    <= abort_s || (last_s && !ch_valid_s);
            busy_r    <= |busy_vec_s;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic sel_s;
        assign sel_s = (wr_ch_r == 6'(i));
        lamp_fade_ch #(
            .PWM_W(PWM_W)
        ) u_ch (
            .clk12    (clk12),
            .reset    (reset),
            .wr_tgt   (wr_tgt_r && sel_s),
            .wr_rate  (wr_rate_r && sel_s),
            .wr_data  (data_r),
            .commit   (commit_s),
            .all_off  (all_off_s),
            .tick     (tick_s),
            .cnt      (cnt_r),
            .cnt_wrap (wrap_s),
            .pwm      (pwm_o[i]),
            .busy     (busy_vec_s[i])
        );
    end

    assign busy_o      = busy_r;
    assign applied_o   = applied_r;
    assign frame_err_o = ferr_r;

endmodule
